// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: IDLE -> FETCH (waits out imem stalls) -> EXEC, HALT on finish/fault.
// Optional wait-state timeout is built only when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_addr,
  input  logic        finish,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic        imem_waitrequest,
  input  logic [31:0] imem_readdata,
  output logic [31:0] instruction_word,
  output logic        state,
  output logic        active,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  state_e      st_q, st_d;
  logic [31:0] iword_q, iword_d;
  logic        fault_q, fault_d;
  logic        aligned;
  logic        rd_req;
  logic        timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
  end

  assign aligned = (pc_addr[1:0] == 2'b00);
  assign rd_req  = (st_q == S_FETCH) && !finish && aligned;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 32) ? 32 : CntRaw);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter sits at zero outside stalled FETCH cycles, so it is clear on every FETCH entry.
  always_comb begin
    cnt_d = '0;
    if (rd_req && imem_waitrequest) cnt_d = cnt_q + 1'b1;
  end

  assign timeout = rd_req && imem_waitrequest && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    st_d    = st_q;
    iword_d = iword_q;
    fault_d = fault_q;
    case (st_q)
      S_IDLE:  st_d = S_FETCH;
      S_FETCH: begin
        if (finish) begin
          st_d = S_HALT;
        end else if (!aligned || timeout) begin
          fault_d = 1'b1;
          st_d    = S_HALT;
        end else if (!imem_waitrequest) begin
          iword_d = imem_readdata;
          st_d    = S_EXEC;
        end
      end
      S_EXEC:  st_d = S_FETCH;
      S_HALT:  st_d = S_HALT;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= S_IDLE;
      iword_q <= '0;
      fault_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      iword_q <= iword_d;
      fault_q <= fault_d;
    end
  end

  assign imem_address     = pc_addr;
  assign imem_read        = rd_req;
  assign instruction_word = iword_q;
  assign state            = (st_q == S_EXEC);
  assign active           = (st_q == S_FETCH) || (st_q == S_EXEC);
  assign fault            = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for halt/stall, random run vs a flag-based model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, finish, imem_waitrequest;
  logic [31:0] pc_addr, imem_readdata;
  logic [31:0] imem_address, instruction_word;
  logic        imem_read, state, active, fault;

  always #5 clk = ~clk;

  fetch_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_addr          (pc_addr),
    .finish           (finish),
    .imem_address     (imem_address),
    .imem_read        (imem_read),
    .imem_waitrequest (imem_waitrequest),
    .imem_readdata    (imem_readdata),
    .instruction_word (instruction_word),
    .state            (state),
    .active           (active),
    .fault            (fault)
  );

  typedef struct {
    logic        r;
    logic [31:0] pc;
    logic        w;
    logic [31:0] rd;
    logic        e_rd;
    logic        e_st;
    logic        e_act;
    logic [31:0] e_iw;
    logic        e_f;
  } vec_t;

  vec_t        tbl[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  localparam logic [31:0] P0 = 32'hBFC0_0000;
  localparam logic [31:0] R1 = 32'h2402_0005;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic [31:0] pc, input logic w, input logic [31:0] rd,
                     input logic erd, input logic est, input logic eact,
                     input logic [31:0] eiw, input logic ef);
    vec_t v;
    v.r = r; v.pc = pc; v.w = w; v.rd = rd;
    v.e_rd = erd; v.e_st = est; v.e_act = eact; v.e_iw = eiw; v.e_f = ef;
    tbl.push_back(v);
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic [31:0] pc, input logic w, input logic [31:0] rd);
    reset            = r;
    pc_addr          = pc;
    finish           = (pc == 32'h0);
    imem_waitrequest = w;
    imem_readdata    = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: plain flags derived from the operating rules.
  bit          m_started, m_halt, m_exec, m_fault;
  logic [31:0] m_iw;
  int unsigned m_waits;

  initial begin
    // Cycle sequence: reset, IDLE, zero-wait fetches, 3-wait fetch, reset mid-wait,
    // finish -> HALT, misaligned -> fault/HALT, reset clears fault.
    add(1, P0,        0, R1,           0, 0, 0, 32'h0, 0);
    add(0, P0,        0, R1,           0, 0, 0, 32'h0, 0);
    add(0, P0,        0, R1,           1, 0, 1, 32'h0, 0);
    add(0, P0,        0, DB,           0, 1, 1, R1, 0);
    add(0, P0 + 4,    0, 32'h1111_1111, 1, 0, 1, R1, 0);
    add(0, P0 + 4,    0, DB,           0, 1, 1, 32'h1111_1111, 0);
    add(0, P0 + 8,    1, DB,           1, 0, 1, 32'h1111_1111, 0);
    add(0, P0 + 8,    1, DB,           1, 0, 1, 32'h1111_1111, 0);
    add(0, P0 + 8,    1, DB,           1, 0, 1, 32'h1111_1111, 0);
    add(0, P0 + 8,    0, 32'h8C22_0000, 1, 0, 1, 32'h1111_1111, 0);
    add(0, P0 + 8,    0, DB,           0, 1, 1, 32'h8C22_0000, 0);
    add(0, P0 + 12,   1, DB,           1, 0, 1, 32'h8C22_0000, 0);
    add(1, P0 + 12,   1, DB,           1, 0, 1, 32'h8C22_0000, 0);
    add(0, P0,        0, DB,           0, 0, 0, 32'h0, 0);
    add(0, P0,        0, 32'h3C1D_1000, 1, 0, 1, 32'h0, 0);
    add(0, P0,        0, DB,           0, 1, 1, 32'h3C1D_1000, 0);
    add(0, 32'h0,     0, 32'h1234_5678, 0, 0, 1, 32'h3C1D_1000, 0);
    add(0, 32'h0,     0, 32'h1234_5678, 0, 0, 0, 32'h3C1D_1000, 0);
    add(1, 32'h0,     0, DB,           0, 0, 0, 32'h3C1D_1000, 0);
    add(0, P0 + 2,    0, R1,           0, 0, 0, 32'h0, 0);
    add(0, P0 + 2,    0, R1,           0, 0, 1, 32'h0, 0);
    add(0, P0,        0, R1,           0, 0, 0, 32'h0, 1);
    add(0, P0,        0, R1,           0, 0, 0, 32'h0, 1);
    add(1, P0,        0, R1,           0, 0, 0, 32'h0, 1);
    add(0, P0,        0, R1,           0, 0, 0, 32'h0, 0);

    drive(1'b1, P0, 1'b0, R1);
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].pc, tbl[i].w, tbl[i].rd);
      chk($sformatf("vec%0d imem_read", i),        imem_read,        tbl[i].e_rd);
      chk($sformatf("vec%0d state", i),            state,            tbl[i].e_st);
      chk($sformatf("vec%0d active", i),           active,           tbl[i].e_act);
      chk($sformatf("vec%0d instruction_word", i), instruction_word, tbl[i].e_iw);
      chk($sformatf("vec%0d fault", i),            fault,            tbl[i].e_f);
      chk($sformatf("vec%0d imem_address", i),     imem_address,     tbl[i].pc);
      tick();
    end

    // Now in FETCH: jump to 0 halts with no read, then HALT holds for 20 cycles.
    drive(1'b0, 32'h0, 1'b0, R1);
    chk("finish_fetch imem_read", imem_read, 1'b0);
    chk("finish_fetch active", active, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'h0, 1'($urandom_range(0, 1)), $urandom);
      chk($sformatf("halt%0d state", i), state, 1'b0);
      chk($sformatf("halt%0d active", i), active, 1'b0);
      chk($sformatf("halt%0d imem_read", i), imem_read, 1'b0);
      chk($sformatf("halt%0d fault", i), fault, 1'b0);
      tick();
    end

    // Waitrequest stuck high.
    drive(1'b1, P0, 1'b1, DB);
    tick();
    drive(1'b0, P0, 1'b1, DB);
    tick();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, P0, 1'b1, DB);
      chk($sformatf("tmo_wait%0d imem_read", i), imem_read, 1'b1);
      chk($sformatf("tmo_wait%0d active", i), active, 1'b1);
      tick();
    end
    drive(1'b0, P0, 1'b1, DB);
    chk("tmo fault", fault, 1'b1);
    chk("tmo active", active, 1'b0);
    chk("tmo imem_read", imem_read, 1'b0);
`else
    begin
      int unsigned bad = 0;
      for (int i = 0; i < 1000; i++) begin
        drive(1'b0, P0, 1'b1, DB);
        if (!(imem_read === 1'b1 && active === 1'b1 && state === 1'b0)) bad++;
        tick();
      end
      chk("stuck_wait bad_cycles", bad, 0);
      chk("stuck_wait fault", fault, 1'b0);
      chk("stuck_wait active", active, 1'b1);
      chk("stuck_wait imem_read", imem_read, 1'b1);
    end
`endif

    // Randomized run against the model.
    drive(1'b1, P0, 1'b0, R1);
    tick();
    m_started = 0; m_halt = 0; m_exec = 0; m_fault = 0; m_iw = '0; m_waits = 0;
    for (int c = 0; c < 600; c++) begin
      logic        r, w, al, e_rd;
      logic [31:0] pc, rd;
      int unsigned kind;
      r    = ($urandom_range(0, 39) == 0);
      kind = $urandom_range(0, 29);
      if (kind == 0)      pc = 32'h0;
      else if (kind == 1) pc = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else                pc = ($urandom | 32'h100) & 32'hFFFF_FFFC;
      w  = ($urandom_range(0, 2) == 0);
      rd = $urandom;
      al = ((pc & 32'h3) == 32'h0);
      drive(r, pc, w, rd);

      e_rd = m_started && !m_halt && !m_exec && (pc != 0) && al;
      chk($sformatf("rnd%0d imem_read", c), imem_read, e_rd);
      chk($sformatf("rnd%0d state", c), state, m_exec);
      chk($sformatf("rnd%0d active", c), active, m_started && !m_halt);
      chk($sformatf("rnd%0d instruction_word", c), instruction_word, m_iw);
      chk($sformatf("rnd%0d fault", c), fault, m_fault);

      if (r) begin
        m_started = 0; m_halt = 0; m_exec = 0; m_fault = 0; m_iw = '0; m_waits = 0;
      end else if (!m_started) begin
        m_started = 1; m_waits = 0;
      end else if (m_halt) begin
        m_halt = 1;
      end else if (m_exec) begin
        m_exec = 0; m_waits = 0;
      end else if (pc == 0) begin
        m_halt = 1;
      end else if (!al) begin
        m_fault = 1; m_halt = 1;
      end else if (w) begin
        m_waits++;
`ifdef FETCH_TIMEOUT_EN
        if (m_waits == 4) begin
          m_fault = 1; m_halt = 1;
        end
`endif
      end else begin
        m_iw = rd; m_exec = 1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer for the harvard core, sitting directly downstream of the program counter and upstream of decode/execute. It turns the PC address into reads on the instruction-memory bus, handles memory wait states, and holds the fetched word stable for the execute cycle. It generates the FETCH/EXEC `state` strobe that the PC uses to advance, and stops the core when the PC signals `finish`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum consecutive waitrequest cycles tolerated in FETCH. Only used with `FETCH_TIMEOUT_EN`.

Ports:
- `clk` input 1: core clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `pc_addr` input 32: current PC address (`addr` from the PC).
- `finish` input 1: PC exit indication, high while `pc_addr == 0`.
- `imem_address` output 32: instruction-memory byte address. Combinational copy of `pc_addr`.
- `imem_read` output 1: read request to instruction memory.
- `imem_waitrequest` input 1: memory stall. The read completes in a cycle where `imem_read=1` and `imem_waitrequest=0`.
- `imem_readdata` input 32: instruction word. Sampled only on the completing cycle.
- `instruction_word` output 32: registered fetched instruction, fed to the PC and decode.
- `state` output 1: high for exactly the EXEC cycle. The PC advances at the end of that cycle.
- `active` output 1: high while the core is running; low in IDLE and HALT.
- `fault` output 1: sticky error flag (misaligned fetch or timeout).

## Operation
- States are IDLE, FETCH, EXEC and HALT.
- Reset values: state register = IDLE, `instruction_word=0`, `state=0`, `imem_read=0`, `active=0`, `fault=0`, timeout counter = 0.
- IDLE
  - Always goes to FETCH on the next cycle.
  - Lasts exactly one cycle after reset is released.
- FETCH
  - Outputs: `active=1`.
  - Priority 1: if `finish=1`, go to HALT. `imem_read=0` this cycle and no bus read is issued.
  - Priority 2: if `pc_addr[1:0] != 0`, set `fault=1` and go to HALT. `imem_read=0`.
  - Otherwise `imem_read=1`.
    - `imem_waitrequest=1`: stay in FETCH, with `imem_read` and the address held.
    - `imem_waitrequest=0`: register `instruction_word <= imem_readdata`, then go to EXEC.
- EXEC
  - Outputs: `state=1`, `imem_read=0`, `active=1`.
  - Always goes to FETCH.
  - `instruction_word` stays constant for the whole cycle and until the next completed fetch.
- HALT
  - Outputs: all bus outputs inactive, `active=0`, `state=0`.
  - Only `reset` leaves HALT.
  - `instruction_word` and `fault` hold their values.
- `imem_readdata` is ignored in every cycle except the completing FETCH cycle.
- Reset asserted in any state, including mid-wait in FETCH:
  - the next edge forces the reset values;
  - `imem_read` drops the cycle after reset is sampled;
  - the pending read is abandoned.

## Timing
- Zero-wait-state memory: 2 cycles per instruction (FETCH, EXEC). With N wait cycles: N+2 cycles.
- First `imem_read=1` appears 2 cycles after the reset cycle (reset, then IDLE, then FETCH).
- `instruction_word` updates on the edge that ends the completing FETCH cycle. It is valid throughout the following EXEC cycle.
- `state` is registered-decoded from the state register. It has no combinational path from `imem_waitrequest`.
- `finish` is checked only in FETCH. The PC holds `pc_addr=0` once it reaches it, so HALT is entered on the first FETCH after the jump to 0.
- HALT is entered one cycle after the triggering FETCH cycle. `active` falls on that same edge.

## Configuration
- Macro: `FETCH_TIMEOUT_EN`.
- Defined:
  - An 8..32-bit counter (width sized for `TIMEOUT_CYCLES`) increments each FETCH cycle with `imem_waitrequest=1`.
  - The counter clears on entering FETCH.
  - When the counter reaches `TIMEOUT_CYCLES` while waitrequest is still high, set `fault=1`, drop `imem_read` and go to HALT on the next edge.
- Undefined:
  - No counter is built.
  - FETCH waits indefinitely.
  - `fault` is set only by misalignment.

## Test plan
- Reset, then `pc_addr=0xBFC00000`, waitrequest always 0, readdata `0x24020005` -> `imem_read` high in cycle 2 after reset; `instruction_word=0x24020005` and `state=1` in cycle 3; `state` pulses every 2 cycles.
- Waitrequest held high for 3 cycles on one fetch -> `imem_read` high for 4 cycles with address stable; one `state` pulse; readdata sampled only on the 4th cycle (other-cycle readdata values `0xDEADBEEF` are never captured).
- `pc_addr` becomes 0 -> next FETCH issues no read; HALT entered; `active=0`, `state` stays 0 for 20 cycles; `fault=0`.
- `pc_addr=0xBFC00002` -> `fault=1`, `imem_read` never asserted, HALT; reset clears `fault` to 0.
- With `FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, waitrequest stuck at 1 -> `fault=1` and `active=0` after the 4th wait cycle. Without the macro, same stimulus -> still in FETCH after 1000 cycles, `fault=0`.
- Reset asserted during the 2nd wait cycle of a fetch -> next cycle `imem_read=0`, `instruction_word=0`, `state=0`; normal fetch resumes 2 cycles after reset release.
